// File: rtl/disp_pkg.sv
// disp_pkg: constants and helpers shared by the scan controller and the segment driver.
// Revision: 1.0
`default_nettype none

package disp_pkg;

  localparam int DIGIT_W    = 4;
  localparam int SCAN_W     = 2;
  localparam int NUM_DIGITS = 4;
  localparam logic [DIGIT_W-1:0] MAX_LEVEL = 4'd9;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SCAN_W-1:0]  scan_t;

  function automatic digit_t sat_level(input digit_t lvl);
    return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_prescaler.sv
// disp_prescaler: free-running 0..DIV-1 slot counter with a wrap tick on the last count.
// Revision: 1.0
`default_nettype none

module disp_prescaler #(
  parameter int DIV   = 50000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o     = (cnt_q == CNT_MAX);
  assign cnt_d      = wrap_o ? '0 : cnt_q + CNT_W'(1);
  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit scan initiator; levels are captured via valid/ready and applied only at frame boundaries.
// Revision: 1.0
`default_nettype none

module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] level,
  input  logic               level_valid,
  output logic               level_ready,
  output logic [SCAN_W-1:0]  scan,
  output logic [DIGIT_W-1:0] digit,
  output logic               blank,
  output logic               frame_start
);

  localparam int          CNT_W     = $clog2(DIV);
  localparam logic [31:0] BLANK_U   = 32'(BLANK);
  localparam scan_t       LAST_SCAN = SCAN_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap;

  disp_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next),
    .wrap_o     (wrap)
  );

  scan_t  scan_q, scan_d;
  digit_t digit_q, digit_d;
  digit_t shadow_q, shadow_d;
  logic   pending_q, pending_d;
  logic   ready_q, ready_d;
  logic   blank_q, blank_d;
  logic   fs_q, fs_d;

  logic boundary;
  logic accept;

  assign boundary = wrap & (scan_q == LAST_SCAN);
  assign accept   = level_valid & ready_q;

  // Blank is computed from the count the slot counter is about to hold, so the
  // registered strobe lines up exactly with cnt < BLANK.
  assign blank_d = (32'(cnt_next) < BLANK_U);
  assign scan_d  = wrap ? scan_q + SCAN_W'(1) : scan_q;
  assign fs_d    = boundary;

  // Apply and accept are mutually exclusive: apply needs pending, accept needs ~pending.
  always_comb begin
    pending_d = pending_q;
    shadow_d  = shadow_q;
    digit_d   = digit_q;
    if (boundary && pending_q) begin
      digit_d   = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = sat_level(level);
      pending_d = 1'b1;
    end
    ready_d = ~pending_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= '0;
      digit_q   <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      blank_q   <= (BLANK > 0);
      fs_q      <= 1'b0;
    end else begin
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
    end
  end

  assign level_ready = ready_q;
  assign scan        = scan_q;
  assign digit       = digit_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed and randomized checks of disp_scan_ctrl against a cycle-count reference model.
// Revision: 1.0
`default_nettype none

module tb_disp_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       rst;
  logic [3:0] level;
  logic       level_valid;
  logic       level_ready;
  logic [1:0] scan;
  logic [3:0] digit;
  logic       blank;
  logic       frame_start;

  disp_scan_ctrl #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .scan        (scan),
    .digit       (digit),
    .blank       (blank),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: everything derives from t, the number of edges since reset.
  int t;
  bit m_pending;
  int m_shadow;
  int m_digit;
  bit last_acc;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
  endtask

  task automatic compare_all();
    check("scan",        int'(scan),        (t / DIV) % 4);
    check("blank",       int'(blank),       ((t % DIV) < BLANK) ? 1 : 0);
    check("frame_start", int'(frame_start), (t > 0 && (t % FRAME) == 0) ? 1 : 0);
    check("level_ready", int'(level_ready), m_pending ? 0 : 1);
    check("digit",       int'(digit),       m_digit);
  endtask

  task automatic model_reset();
    t = 0; m_pending = 0; m_shadow = 0; m_digit = 0;
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = level_valid && !m_pending;
    if ((t % FRAME) == FRAME - 1 && m_pending) begin
      m_digit   = m_shadow;
      m_pending = 0;
    end else if (acc) begin
      m_shadow  = (int'(level) > 9) ? 9 : int'(level);
      m_pending = 1;
    end
    t++;
    @(negedge clk);
    compare_all();
    if (acc) level_valid = 1'b0;
    last_acc = acc;
  endtask

  // Called right after a negedge; checks that reset acts before any clock edge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      compare_all();
    end
    rst = 1'b0;
    level_valid = 1'b0;
  endtask

  task automatic offer(input int v);
    bit done;
    done = 0;
    level = 4'(v);
    level_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      tick();
      done = last_acc;
    end
    check("offer_accepted", int'(done), 1);
  endtask

  task automatic run_to_frame();
    bit hit;
    hit = 0;
    for (int i = 0; i < FRAME + 2 && !hit; i++) begin
      tick();
      hit = ((t % FRAME) == 0);
    end
    check("frame_reached", int'(hit), 1);
  endtask

  task automatic run_until_scan(input int s, input int c);
    bit hit;
    hit = 0;
    for (int i = 0; i < FRAME + 2 && !hit; i++) begin
      tick();
      hit = (((t / DIV) % 4) == s) && ((t % DIV) == c);
    end
    check("scan_reached", int'(hit), 1);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0; level = 4'd0; level_valid = 1'b0; last_acc = 0;
    model_reset();
    @(negedge clk);

    // Reset and first slot
    do_reset(3);
    check("rst_scan",  int'(scan), 0);
    check("rst_blank", int'(blank), 1);
    for (int i = 0; i < 8; i++) tick();
    check("scan_after_8", int'(scan), 1);

    // Free run
    for (int i = 0; i < 64; i++) tick();

    // Single-cycle offer mid-frame
    run_until_scan(1, 3);
    offer(5);
    check("hold_before_boundary", int'(digit), 0);
    run_to_frame();
    check("digit_5", int'(digit), 5);
    check("ready_at_frame", int'(level_ready), 1);

    // Saturation
    offer(12); run_to_frame(); check("sat_12", int'(digit), 9);
    offer(0);  run_to_frame(); check("zero",   int'(digit), 0);
    offer(15); run_to_frame(); check("sat_15", int'(digit), 9);
    offer(9);  run_to_frame(); check("keep_9", int'(digit), 9);

    // Back-pressure: 7 waits while 3 is pending
    offer(3);
    level = 4'd7;
    level_valid = 1'b1;
    run_to_frame();
    check("frame_n1_3", int'(digit), 3);
    for (int i = 0; i < 3 && level_valid; i++) tick();
    check("seven_taken", int'(level_valid), 0);
    check("still_3", int'(digit), 3);
    run_to_frame();
    check("frame_n2_7", int'(digit), 7);

    // Reset mid-slot with a pending value
    run_until_scan(1, 0);
    offer(4);
    run_until_scan(2, 5);
    check("pending_4", int'(level_ready), 0);
    do_reset(2);
    for (int i = 0; i < 2 * FRAME; i++) tick();
    check("four_dropped", int'(digit), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!level_valid && $urandom_range(0, 3) == 0) begin
        level = 4'($urandom_range(0, 15));
        level_valid = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
